// File: rtl/fir_stream_pkg.sv
// ---------------------------------------------------------------------------
// fir_stream_pkg : shared constants and FSM encoding for the filter-output
//                  byte serializer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_stream_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;
  localparam int SAMPLE_CNT_W   = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sample_fifo.sv
// ---------------------------------------------------------------------------
// fir_sample_fifo : single-clock FIFO with first-word-fall-through head output,
//                   word count and full/empty flags.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok, pop_ok;

  // Guards make an illegal push/pop a no-op instead of corrupting pointers.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/fir_result_serializer.sv
// ---------------------------------------------------------------------------
// fir_result_serializer : captures filter results at the sample cadence and
//                         drains them MSB-first as a valid/ready byte stream.
//                         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_result_serializer
  import fir_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_W-1:0]       filtered_in,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    clr_ovf,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [SAMPLE_CNT_W-1:0] sample_count
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    overflow_q, overflow_d;
  logic [SAMPLE_CNT_W-1:0] count_q, count_d;
  ser_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic                    strobe, push, pop, handshake, last_byte;
  logic                    fifo_full, fifo_empty;
  logic [DATA_W-1:0]       fifo_head;

  assign strobe    = en && (div_q == DIV_W'(SAMPLE_DIV - 1));
  // Fullness is taken from the registered count, so a pop in the same cycle never frees a slot.
  assign push      = strobe && !fifo_full;
  assign handshake = tx_valid_q && tx_ready;
  assign last_byte = (idx_q == '0);

  assign div_d      = (!en || strobe) ? '0 : div_q + DIV_W'(1);
  assign overflow_d = (strobe && fifo_full) ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  assign count_d    = push ? count_q + SAMPLE_CNT_W'(1) : count_q;

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (filtered_in),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
      ST_SEND: if (handshake && last_byte && fifo_empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (((state_q == ST_IDLE) && !fifo_empty) ||
        ((state_q == ST_SEND) && handshake && last_byte && !fifo_empty)) begin
      // Load the next word: MSB byte goes straight out, the rest waits in the shifter.
      pop        = 1'b1;
      tx_valid_d = 1'b1;
      tx_data_d  = fifo_head[DATA_W-1 -: 8];
      shift_d    = fifo_head << 8;
      idx_d      = IDX_W'(BYTES - 1);
    end else if ((state_q == ST_SEND) && handshake) begin
      if (last_byte) begin
        tx_valid_d = 1'b0;
      end else begin
        tx_data_d = shift_q[DATA_W-1 -: 8];
        shift_d   = shift_q << 8;
        idx_d     = idx_q - IDX_W'(1);
      end
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign overflow     = overflow_q;
  assign sample_count = count_q;

endmodule

`default_nettype wire
